// File: rtl/dtg_param_if.sv
// Timing bus between the display timing generator and the pixel pipeline.
interface dtg_param_if #(
  parameter int CNT_W = 12,
  parameter int PIX_W = 32,
  parameter int FRM_W = 16
);
  logic             pix_en;
  logic             soft_restart;
  logic             horiz_sync;
  logic             vert_sync;
  logic             video_on;
  logic             hblank;
  logic             vblank;
  logic [CNT_W-1:0] pixel_row;
  logic [CNT_W-1:0] pixel_column;
  logic [PIX_W-1:0] pix_num;
  logic             line_start;
  logic             frame_start;
  logic [FRM_W-1:0] frame_count;

  modport master (
    input  pix_en, soft_restart,
    output horiz_sync, vert_sync, video_on, hblank, vblank,
           pixel_row, pixel_column, pix_num, line_start, frame_start, frame_count
  );

  modport slave (
    output pix_en, soft_restart,
    input  horiz_sync, vert_sync, video_on, hblank, vblank,
           pixel_row, pixel_column, pix_num, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/dtg_param.sv
// Parametrised display timing generator: raster position, sync/blank decode,
// line/frame strobes, active-pixel index and frame counter, all registered.
//   state  | meaning
//   ST_PRE | after reset/soft restart; outputs at reset values, waiting for pix_en
//   ST_RUN | raster advancing one position per enabled cycle
module dtg_param #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 12,
  parameter int PIX_W     = 32,
  parameter int FRM_W     = 16
) (
  input  logic         clock,
  input  logic         rst_n,
  dtg_param_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("dtg_param: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {ST_PRE, ST_RUN} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0] col_d, row_d;
  logic [PIX_W-1:0] pix_d;
  logic [FRM_W-1:0] fc_d;
  logic             ls_d, fs_d, von_d, hb_d, vb_d, hs_d, vs_d;
  logic             run_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= ST_PRE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (vid.soft_restart) state_d = ST_PRE;
    else if (vid.pix_en)  state_d = ST_RUN;
  end

  // Next-position computation plus decode of that position, so every
  // registered output describes the same raster point.
  always_comb begin
    col_d = vid.pixel_column;
    row_d = vid.pixel_row;
    pix_d = vid.pix_num;
    fc_d  = vid.frame_count;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (vid.soft_restart) begin
      col_d = '0;
      row_d = '0;
      pix_d = '0;
      fc_d  = '0;
    end else if (vid.pix_en) begin
      if (state_q == ST_PRE) begin
        col_d = '0;
        row_d = '0;
        pix_d = '0;
        ls_d  = 1'b1;
        fs_d  = 1'b1;
      end else begin
        if (vid.video_on) pix_d = vid.pix_num + PIX_W'(1);
        if (vid.pixel_column == H_LAST) begin
          col_d = '0;
          ls_d  = 1'b1;
          if (vid.pixel_row == V_LAST) begin
            row_d = '0;
            pix_d = '0;
            fc_d  = vid.frame_count + FRM_W'(1);
            fs_d  = 1'b1;
          end else begin
            row_d = vid.pixel_row + CNT_W'(1);
          end
        end else begin
          col_d = vid.pixel_column + CNT_W'(1);
        end
      end
    end

    // In the pre-start state the decodes stay at their reset levels.
    run_d = (state_d == ST_RUN);
    von_d = run_d && (col_d < H_ACT_C) && (row_d < V_ACT_C);
    hb_d  = run_d && (col_d >= H_ACT_C);
    vb_d  = run_d && (row_d >= V_ACT_C);
    hs_d  = (run_d && col_d >= HS_FIRST && col_d <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
    vs_d  = (run_d && row_d >= VS_FIRST && row_d <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vid.pixel_column <= '0;
      vid.pixel_row    <= '0;
      vid.pix_num      <= '0;
      vid.frame_count  <= '0;
      vid.line_start   <= 1'b0;
      vid.frame_start  <= 1'b0;
      vid.video_on     <= 1'b0;
      vid.hblank       <= 1'b0;
      vid.vblank       <= 1'b0;
      vid.horiz_sync   <= ~HSYNC_POL;
      vid.vert_sync    <= ~VSYNC_POL;
    end else begin
      vid.pixel_column <= col_d;
      vid.pixel_row    <= row_d;
      vid.pix_num      <= pix_d;
      vid.frame_count  <= fc_d;
      vid.line_start   <= ls_d;
      vid.frame_start  <= fs_d;
      vid.video_on     <= von_d;
      vid.hblank       <= hb_d;
      vid.vblank       <= vb_d;
      vid.horiz_sync   <= hs_d;
      vid.vert_sync    <= vs_d;
    end
  end

endmodule

// File: tb/tb_dtg_param.sv
// Bench for dtg_param: three configurations run in lockstep against a raster
// model built on a linear position index within the frame.
module tb_dtg_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n, pix_en, soft_restart;

  dtg_param_if #(.CNT_W(12), .PIX_W(32), .FRM_W(16)) if0 ();
  dtg_param_if #(.CNT_W(12), .PIX_W(32), .FRM_W(16)) if1 ();
  dtg_param_if #(.CNT_W(12), .PIX_W(32), .FRM_W(16)) if2 ();

  assign if0.pix_en = pix_en;  assign if0.soft_restart = soft_restart;
  assign if1.pix_en = pix_en;  assign if1.soft_restart = soft_restart;
  assign if2.pix_en = pix_en;  assign if2.soft_restart = soft_restart;

  dtg_param u0 (.clock(clock), .rst_n(rst_n), .vid(if0.master));

  dtg_param #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
              .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
              .HSYNC_POL(1'b1), .VSYNC_POL(1'b1))
    u1 (.clock(clock), .rst_n(rst_n), .vid(if1.master));

  dtg_param #(.H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
              .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(1))
    u2 (.clock(clock), .rst_n(rst_n), .vid(if2.master));

  typedef struct packed {
    logic        hs, vs, von, hb, vb, ls, fs;
    logic [11:0] row, col;
    logic [31:0] pix;
    logic [15:0] fc;
  } out_t;

  out_t a0, a1, a2;
  assign a0 = {if0.horiz_sync, if0.vert_sync, if0.video_on, if0.hblank, if0.vblank,
               if0.line_start, if0.frame_start, if0.pixel_row, if0.pixel_column,
               if0.pix_num, if0.frame_count};
  assign a1 = {if1.horiz_sync, if1.vert_sync, if1.video_on, if1.hblank, if1.vblank,
               if1.line_start, if1.frame_start, if1.pixel_row, if1.pixel_column,
               if1.pix_num, if1.frame_count};
  assign a2 = {if2.horiz_sync, if2.vert_sync, if2.video_on, if2.hblank, if2.vblank,
               if2.line_start, if2.frame_start, if2.pixel_row, if2.pixel_column,
               if2.pix_num, if2.frame_count};

  int cfg_ha [3] = '{640, 8, 20};
  int cfg_hf [3] = '{16, 2, 3};
  int cfg_hs [3] = '{96, 2, 4};
  int cfg_hb [3] = '{48, 2, 5};
  int cfg_va [3] = '{480, 4, 6};
  int cfg_vf [3] = '{10, 1, 2};
  int cfg_vs [3] = '{2, 1, 3};
  int cfg_vb [3] = '{33, 1, 1};
  bit cfg_hp [3] = '{1'b0, 1'b1, 1'b0};
  bit cfg_vp [3] = '{1'b0, 1'b1, 1'b0};

  bit          m_started [3];
  bit          m_adv [3];
  int          m_idx [3];
  logic [15:0] m_fc [3];

  int n_vec = 0;
  int n_bad = 0;

  function automatic int h_total(int i);
    return cfg_ha[i] + cfg_hf[i] + cfg_hs[i] + cfg_hb[i];
  endfunction

  function automatic int v_total(int i);
    return cfg_va[i] + cfg_vf[i] + cfg_vs[i] + cfg_vb[i];
  endfunction

  function automatic out_t dut_out(int i);
    case (i)
      0:       return a0;
      1:       return a1;
      default: return a2;
    endcase
  endfunction

  function automatic out_t model_out(int i);
    out_t e;
    int   col, row, ha, va, hs0, vs0;
    e = '0;
    ha = cfg_ha[i];
    va = cfg_va[i];
    if (!m_started[i]) begin
      e.hs = ~cfg_hp[i];
      e.vs = ~cfg_vp[i];
      return e;
    end
    col = m_idx[i] % h_total(i);
    row = m_idx[i] / h_total(i);
    hs0 = ha + cfg_hf[i];
    vs0 = va + cfg_vf[i];
    e.row = 12'(row);
    e.col = 12'(col);
    e.von = (col < ha) && (row < va);
    e.hb  = (col >= ha);
    e.vb  = (row >= va);
    e.hs  = (col >= hs0 && col < hs0 + cfg_hs[i]) ? cfg_hp[i] : ~cfg_hp[i];
    e.vs  = (row >= vs0 && row < vs0 + cfg_vs[i]) ? cfg_vp[i] : ~cfg_vp[i];
    // active pixels strictly before this position in the frame
    e.pix = 32'(((row < va) ? row : va) * ha + ((row < va) ? ((col < ha) ? col : ha) : 0));
    e.ls  = m_adv[i] && (col == 0);
    e.fs  = m_adv[i] && (m_idx[i] == 0);
    e.fc  = m_fc[i];
    return e;
  endfunction

  task automatic model_clear(int i);
    m_started[i] = 1'b0;
    m_adv[i]     = 1'b0;
    m_idx[i]     = 0;
    m_fc[i]      = '0;
  endtask

  task automatic model_step(int i, bit pe, bit sr);
    if (sr) begin
      model_clear(i);
    end else if (!pe) begin
      m_adv[i] = 1'b0;
    end else if (!m_started[i]) begin
      m_started[i] = 1'b1;
      m_adv[i]     = 1'b1;
      m_idx[i]     = 0;
    end else begin
      m_adv[i] = 1'b1;
      m_idx[i] = (m_idx[i] + 1) % (h_total(i) * v_total(i));
      if (m_idx[i] == 0) m_fc[i] = m_fc[i] + 16'd1;
    end
  endtask

  task automatic check_out(int i, out_t a, out_t e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL dut%0d @%0t got row=%0d col=%0d hs=%b vs=%b von=%b hb=%b vb=%b ls=%b fs=%b pix=%0d fc=%0d | exp row=%0d col=%0d hs=%b vs=%b von=%b hb=%b vb=%b ls=%b fs=%b pix=%0d fc=%0d",
               i, $time, a.row, a.col, a.hs, a.vs, a.von, a.hb, a.vb, a.ls, a.fs, a.pix, a.fc,
               e.row, e.col, e.hs, e.vs, e.von, e.hb, e.vb, e.ls, e.fs, e.pix, e.fc);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // one clock: drive at negedge, update model at posedge, compare just after
  task automatic step(bit r, bit pe, bit sr);
    @(negedge clock);
    rst_n = r;
    pix_en = pe;
    soft_restart = sr;
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      if (!r) model_clear(i);
      else    model_step(i, pe, sr);
    end
    #1;
    for (int i = 0; i < 3; i++) check_out(i, dut_out(i), model_out(i));
  endtask

  typedef struct {
    bit pe, sr;
    int col, row;
    bit von, ls, fs;
    int pix;
  } vec_t;

  vec_t tbl [9];

  int cnt_hs, cnt_hb, cnt_ls, first_hs, max_pix, pix_at_last;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 0};
    tbl[1] = '{1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1};
    tbl[2] = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1};
    tbl[3] = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1};
    tbl[4] = '{1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b0, 2};
    tbl[5] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[6] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0};
    tbl[7] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 0};
    tbl[8] = '{1'b1, 1'b0, 1, 0, 1'b1, 1'b0, 1'b0, 1};

    rst_n = 1'b0;
    pix_en = 1'b1;
    soft_restart = 1'b0;
    for (int i = 0; i < 3; i++) model_clear(i);

    // reset held with pix_en high
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);

    // table vectors against the small configuration
    foreach (tbl[k]) begin
      step(1'b1, tbl[k].pe, tbl[k].sr);
      n_vec++;
      if (if1.pixel_column != 12'(tbl[k].col) || if1.pixel_row != 12'(tbl[k].row) ||
          if1.video_on != tbl[k].von || if1.line_start != tbl[k].ls ||
          if1.frame_start != tbl[k].fs || if1.pix_num != 32'(tbl[k].pix)) begin
        n_bad++;
        $display("FAIL tbl%0d got col=%0d row=%0d von=%b ls=%b fs=%b pix=%0d exp col=%0d row=%0d von=%b ls=%b fs=%b pix=%0d",
                 k, if1.pixel_column, if1.pixel_row, if1.video_on, if1.line_start,
                 if1.frame_start, if1.pix_num, tbl[k].col, tbl[k].row, tbl[k].von,
                 tbl[k].ls, tbl[k].fs, tbl[k].pix);
      end
    end

    // default config: three free-running lines
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    cnt_hs = 0; cnt_hb = 0; cnt_ls = 0; first_hs = -1;
    for (int k = 0; k < 2400; k++) begin
      if (k > 0) step(1'b1, 1'b1, 1'b0);
      if (k < 800) begin
        if (if0.horiz_sync == 1'b0) begin
          cnt_hs++;
          if (first_hs < 0) first_hs = int'(if0.pixel_column);
        end
        if (if0.hblank) cnt_hb++;
      end
      if (if0.line_start) cnt_ls++;
    end
    check_int("hsync_low_cycles", cnt_hs, 96);
    check_int("hsync_first_col", first_hs, 656);
    check_int("hblank_cycles", cnt_hb, 160);
    check_int("line_start_count", cnt_ls, 3);

    // small config: one full frame and its wrap
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    max_pix = 0; pix_at_last = -1;
    for (int k = 0; k < 98; k++) begin
      step(1'b1, 1'b1, 1'b0);
      if (int'(if1.pix_num) > max_pix && if1.video_on) max_pix = int'(if1.pix_num);
      if (if1.pixel_column == 12'd7 && if1.pixel_row == 12'd3) pix_at_last = int'(if1.pix_num);
    end
    check_int("small_pix_max", max_pix, 31);
    check_int("small_pix_last_active", pix_at_last, 31);
    check_int("small_wrap_fc", int'(if1.frame_count), 1);
    check_int("small_wrap_fs", int'(if1.frame_start), 1);
    check_int("small_wrap_pix", int'(if1.pix_num), 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      step(1'b1, ($urandom_range(0, 9) < 7), ($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
